udp_tx_builder: RTL and testbench

- Transmit-side counterpart of the UDP receive parser. Turns a transmit request plus a streamed payload into a complete Ethernet II / IPv4 / UDP byte stream.
- The stream carries: preamble, SFD, MAC header, IP header with computed checksum, UDP header, payload, zero padding and CRC-32 FCS.
- Output feeds the RMII TX serializer through a byte-wide valid/ready handshake.
- Sits between the application payload FIFO and the LAN8720 transmit path.

---
 rtl/eth_types_pkg.sv | 45 ++++
 rtl/eth_crc32.sv | 28 ++
 rtl/udp_tx_builder.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_udp_tx_builder.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_types_pkg.sv
// Shared Ethernet/IPv4/UDP transmit types, constants and checksum/CRC helpers.
// Used by udp_tx_builder and eth_crc32.
package eth_types_pkg;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        CSUM       = 4'd1,
        PREAMBLE   = 4'd2,
        ETH_HEADER = 4'd3,
        IP_HEADER  = 4'd4,
        UDP_HEADER = 4'd5,
        PAYLOAD    = 4'd6,
        PAD        = 4'd7,
        FCS        = 4'd8,
        IFG        = 4'd9
    } eth_tx_states;

    localparam logic [7:0]  ETH_PREAMBLE        = 8'h55;
    localparam logic [7:0]  ETH_SFD             = 8'hD5;
    localparam logic [15:0] ETHERTYPE_IPV4      = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP        = 8'h11;
    localparam logic [15:0] ETH_MIN_UDP_PAYLOAD = 16'd18;
    localparam logic [31:0] CRC32_POLY          = 32'hEDB88320;
    localparam logic [15:0] ETH_IFG_CYCLES      = 16'd48;

    // Reflected CRC-32 advanced by one byte, least-significant bit first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] r;
        r = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC32_POLY) : (r >> 1);
        end
        return r;
    endfunction

    // Ones-complement fold of a 32-bit word sum, then inversion.
    function automatic logic [15:0] ip_csum_fold(input logic [31:0] sum);
        logic [31:0] s1;
        logic [31:0] s2;
        s1 = {16'h0000, sum[31:16]} + {16'h0000, sum[15:0]};
        s2 = {16'h0000, s1[31:16]} + {16'h0000, s1[15:0]};
        return ~(16'(s2));
    endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wise Ethernet CRC-32 register; shared by the transmit builder and the receive FCS check.
module eth_crc32
    import eth_types_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] r_crc;

    // CRC state: preset on init, otherwise advance one byte when enabled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_crc <= 32'hFFFF_FFFF;
        end else if (init) begin
            r_crc <= 32'hFFFF_FFFF;
        end else if (en) begin
            r_crc <= crc32_byte(r_crc, data);
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/udp_tx_builder.sv
// Builds a complete Ethernet II / IPv4 / UDP byte stream from a request and a payload stream.
// Build option UDP_TX_IFG_EN: hold busy for a 48-cycle inter-frame gap after the FCS.
module udp_tx_builder
    import eth_types_pkg::*;
#(
    parameter logic [47:0] FPGA_MAC    = 48'h00_1A_2B_3C_4D_5E,
    parameter logic [31:0] FPGA_IP     = 32'hC0_00_02_92,
    parameter logic [15:0] FPGA_PORT   = 16'd5005,
    parameter logic [7:0]  IP_TTL      = 8'd64,
    parameter logic [15:0] MAX_PAYLOAD = 16'd1472
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [47:0] dest_mac,
    input  logic [31:0] dest_ip,
    input  logic [15:0] dest_port,
    input  logic [15:0] payload_len,
    output logic        busy,
    input  logic [7:0]  payload_in,
    input  logic        payload_in_valid,
    output logic        payload_in_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last
);

    eth_tx_states r_state;
    logic [15:0]  r_cnt;
    logic         r_busy;
    logic [7:0]   r_tx_byte;
    logic         r_tx_valid;
    logic         r_tx_last;
    logic         r_tx_crc;
    logic [15:0]  r_ip_id;
    logic [47:0]  r_dest_mac;
    logic [31:0]  r_dest_ip;
    logic [15:0]  r_dest_port;
    logic [15:0]  r_len;
    logic [31:0]  r_csum_acc;
    logic [15:0]  r_ip_csum;

    logic         w_out_free;
    logic         w_start_ok;
    logic         w_crc_init;
    logic         w_crc_en;
    logic         w_pay_last;
    logic         w_pad_last;
    logic         w_short;
    logic [15:0]  w_total_len;
    logic [15:0]  w_udp_len;
    logic [15:0]  w_csum_word;
    logic [111:0] w_eth_hdr;
    logic [159:0] w_ip_hdr;
    logic [63:0]  w_udp_hdr;
    logic [7:0]   w_eth_byte;
    logic [7:0]   w_ip_byte;
    logic [7:0]   w_udp_byte;
    logic [7:0]   w_fcs_byte;
    logic [31:0]  w_crc;
    logic [31:0]  w_crc_cur;

    assign w_out_free  = !r_tx_valid || tx_ready;
    assign w_start_ok  = start && (payload_len >= 16'd1) && (payload_len <= MAX_PAYLOAD);
    assign w_total_len = r_len + 16'd28;
    assign w_udp_len   = r_len + 16'd8;
    assign w_pay_last  = (r_cnt == (r_len - 16'd1));
    assign w_pad_last  = ((r_cnt + r_len) == (ETH_MIN_UDP_PAYLOAD - 16'd1));
    assign w_short     = (r_len < ETH_MIN_UDP_PAYLOAD);

    // Header images, MSByte first; the byte counter walks them from the top.
    assign w_eth_hdr  = {r_dest_mac, FPGA_MAC, ETHERTYPE_IPV4};
    assign w_ip_hdr   = {8'h45, 8'h00, w_total_len, r_ip_id, 16'h4000, IP_TTL, IP_PROTO_UDP,
                         r_ip_csum, FPGA_IP, r_dest_ip};
    assign w_udp_hdr  = {FPGA_PORT, r_dest_port, w_udp_len, 16'h0000};
    assign w_eth_byte = 8'(w_eth_hdr >> {4'd13 - r_cnt[3:0], 3'b000});
    assign w_ip_byte  = 8'(w_ip_hdr >> {5'd19 - r_cnt[4:0], 3'b000});
    assign w_udp_byte = 8'(w_udp_hdr >> {3'd7 - r_cnt[2:0], 3'b000});

    // The byte leaving the output register this cycle is folded in before the FCS is read.
    assign w_crc_en   = r_tx_valid && tx_ready && r_tx_crc;
    assign w_crc_init = (r_state == PREAMBLE) && (r_cnt == 16'd7) && w_out_free;
    assign w_crc_cur  = w_crc_en ? crc32_byte(w_crc, r_tx_byte) : w_crc;
    assign w_fcs_byte = 8'((~w_crc_cur) >> {r_cnt[1:0], 3'b000});

    eth_crc32 u_crc (
        .clk    (clk),
        .resetn (resetn),
        .init   (w_crc_init),
        .en     (w_crc_en),
        .data   (r_tx_byte),
        .crc    (w_crc)
    );

    // IP header word sequence summed during CSUM; the checksum slot counts as zero.
    always_comb begin
        w_csum_word = 16'h0000;
        case (r_cnt[3:0])
            4'd0:    w_csum_word = 16'h4500;
            4'd1:    w_csum_word = w_total_len;
            4'd2:    w_csum_word = r_ip_id;
            4'd3:    w_csum_word = 16'h4000;
            4'd4:    w_csum_word = {IP_TTL, IP_PROTO_UDP};
            4'd5:    w_csum_word = 16'h0000;
            4'd6:    w_csum_word = FPGA_IP[31:16];
            4'd7:    w_csum_word = FPGA_IP[15:0];
            4'd8:    w_csum_word = r_dest_ip[31:16];
            4'd9:    w_csum_word = r_dest_ip[15:0];
            default: w_csum_word = 16'h0000;
        endcase
    end

    // Frame sequencer with registered output byte, valid, last and busy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_cnt       <= 16'd0;
            r_busy      <= 1'b0;
            r_tx_byte   <= 8'h00;
            r_tx_valid  <= 1'b0;
            r_tx_last   <= 1'b0;
            r_tx_crc    <= 1'b0;
            r_ip_id     <= 16'd0;
            r_dest_mac  <= 48'd0;
            r_dest_ip   <= 32'd0;
            r_dest_port <= 16'd0;
            r_len       <= 16'd0;
            r_csum_acc  <= 32'd0;
            r_ip_csum   <= 16'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx_valid <= 1'b0;
                    r_tx_last  <= 1'b0;
                    if (w_start_ok) begin
                        r_dest_mac  <= dest_mac;
                        r_dest_ip   <= dest_ip;
                        r_dest_port <= dest_port;
                        r_len       <= payload_len;
                        r_busy      <= 1'b1;
                        r_csum_acc  <= 32'd0;
                        r_cnt       <= 16'd0;
                        r_state     <= CSUM;
                    end
                end
                CSUM: begin
                    r_csum_acc <= r_csum_acc + {16'h0000, w_csum_word};
                    if (r_cnt == 16'd9) begin
                        r_ip_csum <= ip_csum_fold(r_csum_acc + {16'h0000, w_csum_word});
                        r_cnt     <= 16'd0;
                        r_state   <= PREAMBLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                PREAMBLE: begin
                    if (w_out_free) begin
                        r_tx_valid <= 1'b1;
                        r_tx_crc   <= 1'b0;
                        r_tx_byte  <= (r_cnt == 16'd7) ? ETH_SFD : ETH_PREAMBLE;
                        if (r_cnt == 16'd7) begin
                            r_cnt   <= 16'd0;
                            r_state <= ETH_HEADER;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                ETH_HEADER: begin
                    if (w_out_free) begin
                        r_tx_valid <= 1'b1;
                        r_tx_crc   <= 1'b1;
                        r_tx_byte  <= w_eth_byte;
                        if (r_cnt == 16'd13) begin
                            r_cnt   <= 16'd0;
                            r_state <= IP_HEADER;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                IP_HEADER: begin
                    if (w_out_free) begin
                        r_tx_valid <= 1'b1;
                        r_tx_crc   <= 1'b1;
                        r_tx_byte  <= w_ip_byte;
                        if (r_cnt == 16'd19) begin
                            r_cnt   <= 16'd0;
                            r_state <= UDP_HEADER;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                UDP_HEADER: begin
                    if (w_out_free) begin
                        r_tx_valid <= 1'b1;
                        r_tx_crc   <= 1'b1;
                        r_tx_byte  <= w_udp_byte;
                        if (r_cnt == 16'd7) begin
                            r_cnt   <= 16'd0;
                            r_state <= PAYLOAD;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                PAYLOAD: begin
                    // An upstream gap becomes an idle output cycle rather than an abort.
                    if (w_out_free) begin
                        if (payload_in_valid) begin
                            r_tx_valid <= 1'b1;
                            r_tx_crc   <= 1'b1;
                            r_tx_byte  <= payload_in;
                            if (w_pay_last) begin
                                r_cnt   <= 16'd0;
                                r_state <= w_short ? PAD : FCS;
                            end else begin
                                r_cnt <= r_cnt + 16'd1;
                            end
                        end else begin
                            r_tx_valid <= 1'b0;
                        end
                    end
                end
                PAD: begin
                    if (w_out_free) begin
                        r_tx_valid <= 1'b1;
                        r_tx_crc   <= 1'b1;
                        r_tx_byte  <= 8'h00;
                        if (w_pad_last) begin
                            r_cnt   <= 16'd0;
                            r_state <= FCS;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                FCS: begin
                    // Count 4 means the last FCS byte is presented; free output means it left.
                    if (w_out_free) begin
                        if (r_cnt == 16'd4) begin
                            r_tx_valid <= 1'b0;
                            r_tx_last  <= 1'b0;
                            r_ip_id    <= r_ip_id + 16'd1;
                            r_cnt      <= 16'd0;
`ifdef UDP_TX_IFG_EN
                            r_state    <= IFG;
`else
                            r_state    <= IDLE;
                            r_busy     <= 1'b0;
`endif
                        end else begin
                            r_tx_valid <= 1'b1;
                            r_tx_crc   <= 1'b0;
                            r_tx_byte  <= w_fcs_byte;
                            r_tx_last  <= (r_cnt == 16'd3);
                            r_cnt      <= r_cnt + 16'd1;
                        end
                    end
                end
                IFG: begin
                    r_tx_valid <= 1'b0;
                    if (r_cnt == (ETH_IFG_CYCLES - 16'd1)) begin
                        r_cnt   <= 16'd0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_tx_valid <= 1'b0;
                    r_tx_last  <= 1'b0;
                    r_busy     <= 1'b0;
                    r_cnt      <= 16'd0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign busy             = r_busy;
    assign tx_byte          = r_tx_byte;
    assign tx_valid         = r_tx_valid;
    assign tx_last          = r_tx_last;
    assign payload_in_ready = (r_state == PAYLOAD) && w_out_free;

endmodule

// File: tb/tb_udp_tx_builder.sv
// Self-checking bench for udp_tx_builder: randomized frames against a byte-list frame model.
module tb_udp_tx_builder;

    localparam logic [47:0] FPGA_MAC  = 48'h00_1A_2B_3C_4D_5E;
    localparam logic [31:0] FPGA_IP   = 32'hC0_00_02_92;
    localparam logic [15:0] FPGA_PORT = 16'd5005;
    localparam logic [7:0]  IP_TTL    = 8'd64;
`ifdef UDP_TX_IFG_EN
    localparam int EXP_IFG = 48;
`else
    localparam int EXP_IFG = 0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [47:0] dest_mac = 48'd0;
    logic [31:0] dest_ip = 32'd0;
    logic [15:0] dest_port = 16'd0;
    logic [15:0] payload_len = 16'd0;
    logic        busy;
    logic [7:0]  payload_in = 8'd0;
    logic        payload_in_valid = 1'b0;
    logic        payload_in_ready;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        tx_last;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_ip_id = 16'd0;
    logic [7:0]  pay [0:1599];
    bit          keep_pay = 0;
    logic [7:0]  got_q [$];
    logic [7:0]  exp_q [$];
    int last_pos, bubbles, consumed, stab_err, busy_after;
    bit timed_out;

    always #10 clk = ~clk;

    udp_tx_builder dut (
        .clk(clk), .resetn(resetn), .start(start), .dest_mac(dest_mac), .dest_ip(dest_ip),
        .dest_port(dest_port), .payload_len(payload_len), .busy(busy), .payload_in(payload_in),
        .payload_in_valid(payload_in_valid), .payload_in_ready(payload_in_ready),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last)
    );

    // Reference frame: byte list from the header rules, RFC 791 checksum, bit-serial CRC-32.
    function automatic void build_frame(input logic [47:0] dmac, input logic [31:0] dip,
                                        input logic [15:0] dport, input int len, input logic [15:0] ipid);
        logic [7:0] f [$];
        logic [7:0] b;
        logic [15:0] tl, ul, cs;
        logic [31:0] crc, fcs;
        int sum;
        bit fb;
        tl = 16'(len + 28);
        ul = 16'(len + 8);
        exp_q = {};
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) f.push_back(dmac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) f.push_back(FPGA_MAC[8*i +: 8]);
        f.push_back(8'h08); f.push_back(8'h00);
        f.push_back(8'h45); f.push_back(8'h00); f.push_back(tl[15:8]); f.push_back(tl[7:0]);
        f.push_back(ipid[15:8]); f.push_back(ipid[7:0]); f.push_back(8'h40); f.push_back(8'h00);
        f.push_back(IP_TTL); f.push_back(8'h11); f.push_back(8'h00); f.push_back(8'h00);
        for (int i = 3; i >= 0; i--) f.push_back(FPGA_IP[8*i +: 8]);
        for (int i = 3; i >= 0; i--) f.push_back(dip[8*i +: 8]);
        sum = 0;
        for (int i = 0; i < 10; i++) sum += {f[14+2*i], f[15+2*i]};
        while (sum > 32'h0000FFFF) sum = (sum & 32'h0000FFFF) + (sum >> 16);
        cs = ~sum[15:0];
        f[24] = cs[15:8];
        f[25] = cs[7:0];
        f.push_back(FPGA_PORT[15:8]); f.push_back(FPGA_PORT[7:0]);
        f.push_back(dport[15:8]); f.push_back(dport[7:0]);
        f.push_back(ul[15:8]); f.push_back(ul[7:0]); f.push_back(8'h00); f.push_back(8'h00);
        for (int i = 0; i < len; i++) f.push_back(pay[i]);
        while (f.size() < 60) f.push_back(8'h00);
        crc = 32'hFFFF_FFFF;
        foreach (f[i]) begin
            b = f[i];
            for (int k = 0; k < 8; k++) begin
                fb = crc[0] ^ b[k];
                crc = crc >> 1;
                if (fb) crc = crc ^ 32'hEDB88320;
            end
        end
        fcs = ~crc;
        foreach (f[i]) exp_q.push_back(f[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
    endfunction

    function automatic int first_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
        if (got_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk); resetn = 1'b0;
        @(negedge clk); resetn = 1'b1;
        exp_ip_id = 16'd0;
    endtask

    task automatic run_frame(input logic [47:0] dmac, input logic [31:0] dip, input logic [15:0] dport,
                             input int len, input bit bp, input int gap_at, input int mid_start_at,
                             input int abort_after);
        int ptr = 0, gap_left = 0, cyc = 0, cnt = 0;
        bit done = 0, gap_used = 0, held = 0, first_seen = 0;
        logic [7:0] held_byte = 8'h00;
        logic held_last = 1'b0;
        got_q = {}; last_pos = -1; bubbles = 0; consumed = 0; stab_err = 0; busy_after = 0;
        if (!keep_pay) for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
        for (int i = len; i < len + 8; i++) pay[i] = 8'($urandom);
        @(posedge clk); #1;
        dest_mac = dmac; dest_ip = dip; dest_port = dport; payload_len = 16'(len);
        start = 1'b1; tx_ready = 1'b1; payload_in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        while (!done && cyc < 6000) begin
            tx_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (gap_at >= 0 && !gap_used && ptr == gap_at) begin gap_used = 1; gap_left = 5; end
            if (gap_left > 0) begin payload_in_valid = 1'b0; gap_left--; end
            else payload_in_valid = 1'b1;
            payload_in = pay[ptr];
            if (cyc == mid_start_at) begin
                start = 1'b1; payload_len = 16'd50; dest_port = 16'hBEEF;
            end else start = 1'b0;
            #1;
            if (held && (tx_valid !== 1'b1 || tx_byte !== held_byte || tx_last !== held_last)) stab_err++;
            if (tx_valid === 1'b1) first_seen = 1;
            else if (first_seen) bubbles++;
            if (tx_valid === 1'b1 && tx_ready) begin
                got_q.push_back(tx_byte);
                if (tx_last === 1'b1) begin last_pos = got_q.size() - 1; done = 1; end
            end
            held = (tx_valid === 1'b1) && !tx_ready;
            held_byte = tx_byte; held_last = tx_last;
            if (payload_in_valid && payload_in_ready === 1'b1) begin consumed++; ptr++; end
            if (abort_after >= 0 && got_q.size() >= abort_after) done = 1;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        timed_out = !done;
        if (abort_after < 0) begin
            tx_ready = 1'b1;
            payload_in = pay[ptr];
            payload_in_valid = 1'b1;
            while (busy === 1'b1 && cnt < 200) begin
                #1;
                if (payload_in_ready === 1'b1) consumed++;
                cnt++;
                @(posedge clk); #1;
            end
            busy_after = cnt;
            payload_in_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        #15;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
        checks++; if (tx_last !== 1'b0) begin failures++; $display("FAIL reset_tx_last got %b exp 0", tx_last); end
        checks++; if (tx_byte !== 8'h00) begin failures++; $display("FAIL reset_tx_byte got %h exp 00", tx_byte); end
        checks++; if (payload_in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got %b exp 0", payload_in_ready); end
        @(negedge clk); resetn = 1'b1;
    endtask

    task automatic test_header();
        logic [7:0] ip_ref [20];
        logic [47:0] dm;
        logic [15:0] dp;
        int bad, d;
        ip_ref = '{8'h45, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                   8'hB6, 8'h39, 8'hC0, 8'h00, 8'h02, 8'h92, 8'hC0, 8'h00, 8'h02, 8'h01};
        dm = {16'($urandom), 32'($urandom)};
        dp = 16'($urandom);
        keep_pay = 0;
        run_frame(dm, 32'hC000_0201, dp, 4, 0, -1, -1, -1);
        build_frame(dm, 32'hC000_0201, dp, 4, exp_ip_id);
        checks++; if (timed_out) begin failures++; $display("FAIL header_timeout got %0d bytes exp 72", got_q.size()); end
        d = first_diff();
        checks++; if (d >= 0) begin failures++; $display("FAIL header_frame first diff at %0d size got %0d exp %0d", d, got_q.size(), exp_q.size()); end
        bad = -1;
        if (got_q.size() < 48) bad = 99;
        else for (int i = 0; i < 20; i++) if (bad < 0 && got_q[22+i] !== ip_ref[i]) bad = i;
        checks++; if (bad >= 0) begin failures++; $display("FAIL header_ip_bytes at %0d got %h exp %h", bad, (bad < 20) ? got_q[22+bad] : 8'h00, (bad < 20) ? ip_ref[bad] : 8'h00); end
        checks++; if (got_q.size() < 48 || {got_q[46], got_q[47]} !== 16'h000C) begin failures++; $display("FAIL header_udp_len got size %0d exp 000c", got_q.size()); end
        checks++; if (last_pos != 71) begin failures++; $display("FAIL header_last_pos got %0d exp 71", last_pos); end
        checks++; if (bubbles != 0) begin failures++; $display("FAIL header_bubbles got %0d exp 0", bubbles); end
        checks++; if (consumed != 4) begin failures++; $display("FAIL header_consumed got %0d exp 4", consumed); end
        checks++; if (busy_after != EXP_IFG) begin failures++; $display("FAIL header_busy_after got %0d exp %0d", busy_after, EXP_IFG); end
        exp_ip_id++;
    endtask

    task automatic test_padding();
        logic [47:0] dm;
        int bad, d;
        dm = {16'($urandom), 32'($urandom)};
        pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
        keep_pay = 1;
        run_frame(dm, 32'($urandom), 16'($urandom), 4, 0, -1, -1, -1);
        keep_pay = 0;
        build_frame(dm, dest_ip, dest_port, 4, exp_ip_id);
        checks++; if (got_q.size() != 72) begin failures++; $display("FAIL pad_size got %0d exp 72", got_q.size()); end
        bad = -1;
        if (got_q.size() < 68) bad = 99;
        else for (int i = 54; i < 68; i++) if (bad < 0 && got_q[i] !== 8'h00) bad = i;
        checks++; if (bad >= 0) begin failures++; $display("FAIL pad_zero at %0d got nonzero exp 00", bad); end
        d = first_diff();
        checks++; if (d >= 0) begin failures++; $display("FAIL pad_frame_fcs first diff at %0d got %h exp %h", d, (d < got_q.size()) ? got_q[d] : 8'h00, (d < exp_q.size()) ? exp_q[d] : 8'h00); end
        exp_ip_id++;
    endtask

    task automatic test_backpressure();
        logic [47:0] dm;
        int d;
        dm = {16'($urandom), 32'($urandom)};
        run_frame(dm, 32'($urandom), 16'($urandom), 100, 1, -1, -1, -1);
        build_frame(dm, dest_ip, dest_port, 100, exp_ip_id);
        checks++; if (timed_out) begin failures++; $display("FAIL bp_timeout got %0d bytes exp %0d", got_q.size(), exp_q.size()); end
        d = first_diff();
        checks++; if (d >= 0) begin failures++; $display("FAIL bp_frame first diff at %0d size got %0d exp %0d", d, got_q.size(), exp_q.size()); end
        checks++; if (stab_err != 0) begin failures++; $display("FAIL bp_stable got %0d unstable cycles exp 0", stab_err); end
        checks++; if (consumed != 100) begin failures++; $display("FAIL bp_consumed got %0d exp 100", consumed); end
        exp_ip_id++;
    endtask

    task automatic test_payload_gap();
        logic [47:0] dm;
        int d;
        dm = {16'($urandom), 32'($urandom)};
        run_frame(dm, 32'($urandom), 16'($urandom), 40, 0, 10, -1, -1);
        build_frame(dm, dest_ip, dest_port, 40, exp_ip_id);
        d = first_diff();
        checks++; if (d >= 0) begin failures++; $display("FAIL gap_frame first diff at %0d size got %0d exp %0d", d, got_q.size(), exp_q.size()); end
        checks++; if (bubbles != 5) begin failures++; $display("FAIL gap_idle_cycles got %0d exp 5", bubbles); end
        checks++; if (consumed != 40) begin failures++; $display("FAIL gap_consumed got %0d exp 40", consumed); end
        exp_ip_id++;
    endtask

    task automatic test_boundary();
        int lens [3] = '{1, 18, 1472};
        logic [47:0] dm;
        int d;
        foreach (lens[k]) begin
            dm = {16'($urandom), 32'($urandom)};
            run_frame(dm, 32'($urandom), 16'($urandom), lens[k], 0, -1, -1, -1);
            build_frame(dm, dest_ip, dest_port, lens[k], exp_ip_id);
            d = first_diff();
            checks++; if (d >= 0 || timed_out) begin failures++; $display("FAIL boundary_len%0d first diff at %0d size got %0d exp %0d", lens[k], d, got_q.size(), exp_q.size()); end
            checks++; if (consumed != lens[k]) begin failures++; $display("FAIL boundary_consumed got %0d exp %0d", consumed, lens[k]); end
            exp_ip_id++;
        end
    endtask

    task automatic test_reject();
        int bad_lens [2] = '{0, 1473};
        logic [47:0] dm;
        bit seen;
        int d;
        foreach (bad_lens[k]) begin
            @(posedge clk); #1;
            payload_len = 16'(bad_lens[k]); start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0; seen = 0;
            repeat (10) begin
                if (busy !== 1'b0 || tx_valid !== 1'b0) seen = 1;
                @(posedge clk); #1;
            end
            checks++; if (seen) begin failures++; $display("FAIL reject_len%0d busy got 1 exp 0", bad_lens[k]); end
        end
        do_reset();
        dm = {16'($urandom), 32'($urandom)};
        run_frame(dm, 32'($urandom), 16'h1234, 30, 0, -1, 40, -1);
        build_frame(dm, dest_ip, 16'h1234, 30, exp_ip_id);
        d = first_diff();
        checks++; if (d >= 0) begin failures++; $display("FAIL busy_start_frame first diff at %0d size got %0d exp %0d", d, got_q.size(), exp_q.size()); end
        exp_ip_id++;
        seen = 0;
        repeat (10) begin
            if (busy !== 1'b0) seen = 1;
            @(posedge clk); #1;
        end
        checks++; if (seen) begin failures++; $display("FAIL busy_start_queued got busy 1 exp 0"); end
        dm = {16'($urandom), 32'($urandom)};
        run_frame(dm, 32'($urandom), 16'($urandom), 20, 0, -1, -1, -1);
        build_frame(dm, dest_ip, dest_port, 20, exp_ip_id);
        checks++; if (got_q.size() < 28 || {got_q[26], got_q[27]} !== 16'd1) begin failures++; $display("FAIL second_ip_id got size %0d exp id 0001", got_q.size()); end
        d = first_diff();
        checks++; if (d >= 0) begin failures++; $display("FAIL second_frame first diff at %0d size got %0d exp %0d", d, got_q.size(), exp_q.size()); end
        exp_ip_id++;
    endtask

    task automatic test_reset_mid();
        logic [47:0] dm;
        int d;
        dm = {16'($urandom), 32'($urandom)};
        run_frame(dm, 32'($urandom), 16'($urandom), 64, 0, -1, -1, 27);
        resetn = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midreset_outputs got valid %b busy %b exp 0 0", tx_valid, busy); end
        checks++; if (payload_in_ready !== 1'b0) begin failures++; $display("FAIL midreset_ready got %b exp 0", payload_in_ready); end
        @(negedge clk); resetn = 1'b1;
        exp_ip_id = 16'd0;
        dm = {16'($urandom), 32'($urandom)};
        run_frame(dm, 32'($urandom), 16'($urandom), 25, 0, -1, -1, -1);
        build_frame(dm, dest_ip, dest_port, 25, exp_ip_id);
        checks++; if (got_q.size() < 28 || {got_q[26], got_q[27]} !== 16'd0) begin failures++; $display("FAIL midreset_ip_id got size %0d exp id 0000", got_q.size()); end
        d = first_diff();
        checks++; if (d >= 0) begin failures++; $display("FAIL midreset_frame first diff at %0d size got %0d exp %0d", d, got_q.size(), exp_q.size()); end
        checks++; if (busy_after != EXP_IFG) begin failures++; $display("FAIL ifg_busy got %0d exp %0d", busy_after, EXP_IFG); end
        exp_ip_id++;
    endtask

    initial begin
        test_reset();
        test_header();
        test_padding();
        test_backpressure();
        test_payload_gap();
        test_boundary();
        test_reject();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
